// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program-load and run-control front end for the single-cycle processor.
// A stream of 32-bit instruction words arrives over a valid/ready handshake
// and is written, one word per accepted beat, into consecutive instruction
// memory addresses starting at 0. The processor is held in reset while the
// program loads. The word flagged in_last releases it for exactly RUN_CYCLES
// enabled cycles, after which it is frozen so its state can be inspected.
//
// Parameters
//   ADDR_WIDTH   instruction-memory word-address width (2^ADDR_WIDTH words)
//   RUN_CYCLES   enabled processor cycles after release (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     word-stream valid
//   in_data      instruction word
//   in_last      final word of the program (qualified by in_valid)
//   in_ready     word accepted this cycle when in_valid is also high
//   reload       one-cycle request to abandon everything and start a new load
//   imem_we      instruction-memory write enable (same cycle as acceptance)
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction-memory write data
//   cpu_rst      registered reset to the processor
//   cpu_en       processor clock-enable, high only while running
//   words_loaded words accepted in the current load
//   done         run window completed (sticky until reload/rst)
//   overflow     program exceeded memory capacity (sticky until reload/rst)
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int RUN_CYCLES = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [31:0]           in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  cpu_en,
   output logic [ADDR_WIDTH:0]   words_loaded,
   output logic                  done,
   output logic                  overflow
);

   localparam logic [1:0] ST_LOAD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   // The run counter only ever needs to reach RUN_CYCLES-1.
   localparam int               CNT_W    = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_cnt;
   logic             accept;
   logic             at_top;
   logic             run_end;

   // Handshake and write port are purely combinational so a word is written
   // on the same edge that accepts it. Reload masks ready so a word offered
   // alongside a reload is neither written nor counted.
   always_comb begin
      in_ready   = (state == ST_LOAD) && !reload;
      accept     = in_valid && in_ready;
      imem_we    = accept;
      imem_addr  = words_loaded[ADDR_WIDTH-1:0];
      imem_wdata = in_data;
      cpu_en     = (state == ST_RUN);
      at_top     = &words_loaded[ADDR_WIDTH-1:0];
      run_end    = (state == ST_RUN) && (cycle_cnt == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst || reload) begin
         state        <= ST_LOAD;
         words_loaded <= '0;
         cycle_cnt    <= '0;
         cpu_rst      <= 1'b1;
         done         <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
                  if (in_last) begin
                     state   <= ST_RUN;
                     cpu_rst <= 1'b0;
                  end else if (at_top) begin
                     // Memory is full and the program has not ended: park
                     // with the processor still in reset.
                     state    <= ST_HALT;
                     overflow <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               cycle_cnt <= cycle_cnt + CNT_W'(1);
               if (run_end) begin
                  state <= ST_HALT;
                  done  <= 1'b1;
               end
            end
            ST_HALT: begin
               // Frozen: cpu_rst keeps whatever value it had on entry.
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Drives two imem_loader instances with identical stimulus: A uses the
// default geometry (64 words, 50-cycle run), B a tiny one (4 words, 3-cycle
// run) so capacity overflow is reachable. A cycle-level reference model,
// written in terms of "loading / cycles left to run", predicts every output
// of both instances each cycle. A small table and hand-written sequences add
// fixed expected values for the named corner cases.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   localparam int AW_A = 6;
   localparam int RC_A = 50;
   localparam int AW_B = 2;
   localparam int RC_B = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        reload;

   logic            a_ready, a_we, a_crst, a_en, a_done, a_ovf;
   logic [AW_A-1:0] a_addr;
   logic [31:0]     a_wdata;
   logic [AW_A:0]   a_wl;

   logic            b_ready, b_we, b_crst, b_en, b_done, b_ovf;
   logic [AW_B-1:0] b_addr;
   logic [31:0]     b_wdata;
   logic [AW_B:0]   b_wl;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW_A), .RUN_CYCLES(RC_A)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(a_ready), .reload(reload),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .cpu_rst(a_crst), .cpu_en(a_en), .words_loaded(a_wl),
      .done(a_done), .overflow(a_ovf));

   imem_loader #(.ADDR_WIDTH(AW_B), .RUN_CYCLES(RC_B)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(b_ready), .reload(reload),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .cpu_rst(b_crst), .cpu_en(b_en), .words_loaded(b_wl),
      .done(b_done), .overflow(b_ovf));

   int checks = 0;
   int errors = 0;

   // Reference model: loading or not, and how many enabled cycles remain.
   typedef struct {
      bit loading;
      int run_left;
      int wl;
      bit crst;
      bit done;
      bit ovf;
   } model_t;

   model_t ma, mb;

   // Samples taken mid-cycle (inputs applied, before the edge).
   logic            a_ready_s, a_we_s, a_crst_s, a_en_s;
   logic [AW_A-1:0] a_addr_s;
   logic [AW_A:0]   a_wl_s;
   logic            b_ready_s, b_we_s;
   logic [AW_B-1:0] b_addr_s;

   function automatic model_t reset_model();
      model_t m;
      m.loading = 1'b1; m.run_left = 0; m.wl = 0;
      m.crst = 1'b1; m.done = 1'b0; m.ovf = 1'b0;
      return m;
   endfunction

   function automatic model_t mstep(input model_t m, input int aw, input int rc,
                                    input bit v, input bit l, input bit rl, input bit r);
      model_t n;
      bit acc;
      n = m;
      acc = v && m.loading && !rl;
      if (r || rl) begin
         n = reset_model();
      end else if (acc) begin
         n.wl = m.wl + 1;
         if (l) begin
            n.loading = 1'b0; n.run_left = rc; n.crst = 1'b0;
         end else if (m.wl == (1 << aw) - 1) begin
            n.loading = 1'b0; n.ovf = 1'b1;
         end
      end else if (m.run_left > 0) begin
         n.run_left = m.run_left - 1;
         if (n.run_left == 0) n.done = 1'b1;
      end
      return n;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_one(input string tag, input model_t m, input int aw,
                          input bit v, input bit rl, input logic [31:0] d,
                          input logic ready, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic crst, input logic en,
                          input logic [31:0] wl, input logic dn, input logic ov);
      bit exp_ready, exp_we;
      exp_ready = m.loading && !rl;
      exp_we    = v && exp_ready;
      cmp({tag, ".in_ready"}, 64'(ready), 64'(exp_ready));
      cmp({tag, ".imem_we"}, 64'(we), 64'(exp_we));
      if (exp_we) begin
         cmp({tag, ".imem_addr"}, 64'(addr), 64'(m.wl % (1 << aw)));
         cmp({tag, ".imem_wdata"}, 64'(wdata), 64'(d));
      end
      cmp({tag, ".cpu_rst"}, 64'(crst), 64'(m.crst));
      cmp({tag, ".cpu_en"}, 64'(en), 64'(m.run_left > 0));
      cmp({tag, ".words_loaded"}, 64'(wl), 64'(m.wl));
      cmp({tag, ".done"}, 64'(dn), 64'(m.done));
      cmp({tag, ".overflow"}, 64'(ov), 64'(m.ovf));
   endtask

   // One clock cycle: apply inputs after the falling edge, compare both
   // instances against the model, then advance the model on the rising edge.
   task automatic cycle(input bit v, input logic [31:0] d, input bit l,
                        input bit rl, input bit r, input bit chk);
      @(negedge clk);
      in_valid = v; in_data = d; in_last = l; reload = rl; rst = r;
      #1;
      a_ready_s = a_ready; a_we_s = a_we; a_addr_s = a_addr;
      a_crst_s = a_crst; a_en_s = a_en; a_wl_s = a_wl;
      b_ready_s = b_ready; b_we_s = b_we; b_addr_s = b_addr;
      if (chk) begin
         chk_one("A", ma, AW_A, v, rl, d, a_ready, a_we, 32'(a_addr), a_wdata,
                 a_crst, a_en, 32'(a_wl), a_done, a_ovf);
         chk_one("B", mb, AW_B, v, rl, d, b_ready, b_we, 32'(b_addr), b_wdata,
                 b_crst, b_en, 32'(b_wl), b_done, b_ovf);
      end
      @(posedge clk);
      ma = mstep(ma, AW_A, RC_A, v, l, rl, r);
      mb = mstep(mb, AW_B, RC_B, v, l, rl, r);
   endtask

   typedef struct {
      bit          v;
      logic [31:0] d;
      bit          l;
      bit          ready;
      bit          we;
      logic [5:0]  addr;
      bit          crst;
      bit          en;
      logic [6:0]  wl;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int en_cnt;

      // Normal load on instance A: four words A0..A3 with a one-cycle gap.
      tbl[0] = '{v:1, d:32'hA0, l:0, ready:1, we:1, addr:0, crst:1, en:0, wl:0};
      tbl[1] = '{v:1, d:32'hA1, l:0, ready:1, we:1, addr:1, crst:1, en:0, wl:1};
      tbl[2] = '{v:0, d:32'h00, l:0, ready:1, we:0, addr:0, crst:1, en:0, wl:2};
      tbl[3] = '{v:1, d:32'hA2, l:0, ready:1, we:1, addr:2, crst:1, en:0, wl:2};
      tbl[4] = '{v:1, d:32'hA3, l:1, ready:1, we:1, addr:3, crst:1, en:0, wl:3};
      tbl[5] = '{v:1, d:32'hFF, l:0, ready:0, we:0, addr:0, crst:0, en:1, wl:4};
      tbl[6] = '{v:0, d:32'h00, l:0, ready:0, we:0, addr:0, crst:0, en:1, wl:4};

      in_valid = 0; in_data = 0; in_last = 0; reload = 0; rst = 1;
      ma = reset_model();
      mb = reset_model();
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 1);
      #1;
      cmp("reset.words_loaded", 64'(a_wl), 64'd0);
      cmp("reset.cpu_rst", 64'(a_crst), 64'd1);
      cmp("reset.cpu_en", 64'(a_en), 64'd0);
      cmp("reset.done", 64'(a_done), 64'd0);
      cmp("reset.overflow", 64'(a_ovf), 64'd0);

      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].l, 0, 0, 1);
         cmp($sformatf("tbl%0d.in_ready", i), 64'(a_ready_s), 64'(tbl[i].ready));
         cmp($sformatf("tbl%0d.imem_we", i), 64'(a_we_s), 64'(tbl[i].we));
         if (tbl[i].we) cmp($sformatf("tbl%0d.imem_addr", i), 64'(a_addr_s), 64'(tbl[i].addr));
         cmp($sformatf("tbl%0d.cpu_rst", i), 64'(a_crst_s), 64'(tbl[i].crst));
         cmp($sformatf("tbl%0d.cpu_en", i), 64'(a_en_s), 64'(tbl[i].en));
         cmp($sformatf("tbl%0d.words_loaded", i), 64'(a_wl_s), 64'(tbl[i].wl));
      end

      // Run window: two enabled cycles already covered by the table.
      en_cnt = 2;
      for (int i = 0; i < 60; i++) begin
         cycle(0, 0, 0, 0, 0, 1);
         if (a_en_s) en_cnt++;
      end
      cmp("run.enabled_cycles", 64'(en_cnt), 64'd50);
      #1;
      cmp("run.done", 64'(a_done), 64'd1);
      cmp("run.cpu_en_after", 64'(a_en), 64'd0);
      cmp("run.cpu_rst_held", 64'(a_crst), 64'd0);

      // Stalled stream: a word every third cycle.
      cycle(0, 0, 0, 1, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cycle(1, 32'hB0 + 32'(k), (k == 2), 0, 0, 1);
         cmp("stall.word_we", 64'(a_we_s), 64'd1);
         cmp("stall.word_addr", 64'(a_addr_s), 64'(k));
         if (k < 2) begin
            for (int g = 0; g < 2; g++) begin
               cycle(0, 32'hDEAD, 0, 0, 0, 1);
               cmp("stall.gap_we", 64'(a_we_s), 64'd0);
            end
         end
      end
      cycle(0, 0, 0, 0, 0, 1);
      cmp("stall.release_en", 64'(a_en_s), 64'd1);
      cmp("stall.release_rst", 64'(a_crst_s), 64'd0);

      // Overflow on the 4-word instance B.
      cycle(0, 0, 0, 1, 0, 1);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 32'hC0 + 32'(k), 0, 0, 0, 1);
         if (k < 4) begin
            cmp("ovf.we", 64'(b_we_s), 64'd1);
            cmp("ovf.addr", 64'(b_addr_s), 64'(k));
         end else begin
            cmp("ovf.fifth_ready", 64'(b_ready_s), 64'd0);
            cmp("ovf.fifth_we", 64'(b_we_s), 64'd0);
         end
         if (k == 3) begin
            #1;
            cmp("ovf.flag", 64'(b_ovf), 64'd1);
            cmp("ovf.cpu_rst", 64'(b_crst), 64'd1);
            cmp("ovf.done", 64'(b_done), 64'd0);
         end
      end

      // Reload ten cycles into a run.
      cycle(0, 0, 0, 1, 0, 1);
      cycle(1, 32'hD0, 1, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      #1;
      cmp("midrun.cpu_en", 64'(a_en), 64'd0);
      cmp("midrun.cpu_rst", 64'(a_crst), 64'd1);
      cmp("midrun.words_loaded", 64'(a_wl), 64'd0);
      cmp("midrun.done", 64'(a_done), 64'd0);
      cycle(1, 32'hE0, 1, 0, 0, 1);
      cmp("midrun.new_we", 64'(a_we_s), 64'd1);
      cmp("midrun.new_addr", 64'(a_addr_s), 64'd0);

      // Reload together with a valid word.
      cycle(0, 0, 0, 1, 0, 1);
      cycle(1, 32'hF0, 0, 1, 0, 1);
      cmp("rlvalid.we", 64'(a_we_s), 64'd0);
      #1;
      cmp("rlvalid.words_loaded", 64'(a_wl), 64'd0);

      // Reset after two words of a five-word program.
      cycle(1, 32'h10, 0, 0, 0, 1);
      cycle(1, 32'h11, 0, 0, 0, 1);
      cycle(1, 32'h12, 0, 0, 1, 1);
      #1;
      cmp("rstmid.words_loaded", 64'(a_wl), 64'd0);
      cmp("rstmid.cpu_rst", 64'(a_crst), 64'd1);
      cmp("rstmid.cpu_en", 64'(a_en), 64'd0);
      cmp("rstmid.done", 64'(a_done), 64'd0);
      cmp("rstmid.overflow", 64'(a_ovf), 64'd0);
      cycle(1, 32'h20, 0, 0, 0, 1);
      cmp("rstmid.restart_addr", 64'(a_addr_s), 64'd0);

      // Randomised traffic, checked every cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) == 0), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load and run-control block at the boundary between the simulation environment (or an external host) and the single-cycle processor `top`. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory, holding the processor in reset while loading. On the last word it releases the processor, runs it for a fixed number of cycles, then freezes it so register and data-memory state can be inspected. It is the write-side counterpart to the result-checking side of the processor bench: it puts the program in, and the checker reads results out.

## Interface
- `ADDR_WIDTH`, default 6: instruction-memory word-address width, so capacity is 2^ADDR_WIDTH words.
- `RUN_CYCLES`, default 50: number of enabled processor cycles after release. Legal range is at least 1.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  word-stream valid.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  marks the final word of the program. Qualified by `in_valid`.
- `in_ready`  out  1  block accepts a word this cycle.
- `reload`  in  1  single-cycle request to start a new load.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  write data.
- `cpu_rst`  out  1  reset to the processor, registered.
- `cpu_en`  out  1  processor clock-enable. High only in RUN.
- `words_loaded`  out  ADDR_WIDTH+1  count of words accepted in the current load.
- `done`  out  1  run completed. Sticky until `reload` or `rst`.
- `overflow`  out  1  program exceeded capacity. Sticky until `reload` or `rst`.

## Operation
- States: LOAD, RUN, HALT.
- Reset values: state LOAD, `words_loaded`=0, `cpu_rst`=1, `cpu_en`=0, `done`=0, `overflow`=0, cycle counter 0.
- LOAD:
  - `in_ready`=1. Acceptance is `in_valid & in_ready`.
  - On acceptance, in the same cycle and combinationally: `imem_we`=1, `imem_addr`=`words_loaded[ADDR_WIDTH-1:0]`, `imem_wdata`=`in_data`. At the edge, `words_loaded` increments by 1.
  - If `in_last` is set on the accepted word, the next state is RUN and `cpu_rst` is 0 from that edge onward.
  - If the accepted word is at address 2^ADDR_WIDTH-1 and `in_last` is 0, the word is still written. The next state is HALT with `overflow`=1, `cpu_rst` stays 1, and `done` stays 0.
- RUN:
  - `in_ready`=0, `imem_we`=0, `cpu_rst`=0, `cpu_en`=1.
  - The cycle counter increments every cycle. When it equals RUN_CYCLES-1, the next state is HALT and `done`=1.
- HALT:
  - `in_ready`=0, `imem_we`=0, `cpu_en`=0. `cpu_rst` is held at its prior value (0 after a normal run), so processor state is preserved for inspection.
- `reload`:
  - In any state, `reload` forces the next state to LOAD and, at the edge, clears `words_loaded`, the cycle counter, `done`, and `overflow`, and sets `cpu_rst`=1.
  - `reload` takes priority over a simultaneous acceptance: no write occurs that cycle (`in_ready` is 0 whenever `reload`=1).
- `rst` takes priority over everything and produces the reset values above.
- `imem_we` is never asserted outside LOAD.

## Timing
- Write latency is 0 cycles: the memory write occurs on the same edge as the acceptance.
- Back-to-back acceptance is supported at one word per cycle.
- Release: if `in_last` is accepted at edge N, `cpu_rst`=0 and `cpu_en`=1 in the cycle after N.
- Run window: `cpu_en` is high for exactly RUN_CYCLES cycles. `done` rises on the same edge that `cpu_en` falls.
- `reload` asserted in cycle k: from edge k onward, state is LOAD and `cpu_rst`=1, so the first new word can be accepted in cycle k+1.
- `reload` asserted mid-RUN aborts the run. `done` stays 0.

## Test plan
- **Normal load.** Reset, then stream 4 words 0xA0..0xA3 with `in_last` on the 4th. Required: writes to addresses 0..3 with matching data, `words_loaded`=4, `cpu_rst` falls the cycle after the last word, `cpu_en` high for exactly 50 cycles, then `done`=1 and `cpu_en`=0.
- **Stalled stream.** Assert `in_valid` only every 3rd cycle for 3 words. Required: no write in gap cycles, addresses 0,1,2 written, release happens after the 3rd word.
- **Overflow.** With ADDR_WIDTH=2, send 5 words with no `in_last`. Required: addresses 0..3 written, `overflow`=1 after the 4th, `in_ready`=0 on the 5th, `cpu_rst` stays 1, `done`=0.
- **Reload mid-run.** `reload` pulsed 10 cycles into RUN. Required: `cpu_en`=0 and `cpu_rst`=1 next cycle, `words_loaded`=0, `done`=0; a new 1-word load then writes address 0.
- **Reload with simultaneous valid.** `reload` and `in_valid` high in the same LOAD cycle. Required: `imem_we`=0 that cycle and `words_loaded`=0 afterward.
- **Reset mid-load.** `rst` after 2 of 5 words. Required: all outputs return to their reset values, and the next load starts at address 0.
